brainhack_prog_loader: RTL and testbench

- Writer side of the program-memory interface: fills program memory that the brainhack core later reads and executes.
- Accepts a valid/ready byte stream, for example from a UART receiver.
- Keeps only the eight Brainfuck opcode characters and checks bracket balance and nesting depth against the core's return-stack size.
- Writes a 0x00 terminator, then releases the core from hold.

---
 rtl/brainhack_prog_loader_pkg.sv | 27 ++
 rtl/brainhack_prog_loader_opcode_decode.sv | 19 +
 rtl/brainhack_prog_loader.sv | 141 ++++++++++++++
 tb/tb_brainhack_prog_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/brainhack_prog_loader_pkg.sv
// Shared constants for the brainhack program loader: opcode characters, error codes, FSM states.
package brainhack_prog_loader_pkg;

  localparam logic [7:0] c_op_inc        = 8'h2B;
  localparam logic [7:0] c_op_dec        = 8'h2D;
  localparam logic [7:0] c_op_left       = 8'h3C;
  localparam logic [7:0] c_op_right      = 8'h3E;
  localparam logic [7:0] c_op_open       = 8'h5B;
  localparam logic [7:0] c_op_close      = 8'h5D;
  localparam logic [7:0] c_op_out        = 8'h2E;
  localparam logic [7:0] c_op_in         = 8'h2C;
  localparam logic [7:0] c_terminator    = 8'h00;

  localparam logic [1:0] c_err_none       = 2'b00;
  localparam logic [1:0] c_err_overflow   = 2'b01;
  localparam logic [1:0] c_err_unbalanced = 2'b10;
  localparam logic [1:0] c_err_nesting    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TERM,
    ST_DONE,
    ST_ERR
  } state_e;

endpackage

// File: rtl/brainhack_prog_loader_opcode_decode.sv
// Combinational Brainfuck opcode classifier; zero latency, no flow control.
// Shared with the core's instruction decoder.
module brainhack_opcode_decode
  import brainhack_prog_loader_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic       o_is_opcode,
  output logic       o_is_open,
  output logic       o_is_close
);

  assign o_is_open   = (i_byte == c_op_open);
  assign o_is_close  = (i_byte == c_op_close);
  assign o_is_opcode = (i_byte == c_op_inc)  || (i_byte == c_op_dec)   ||
                       (i_byte == c_op_left) || (i_byte == c_op_right) ||
                       (i_byte == c_op_out)  || (i_byte == c_op_in)    ||
                       o_is_open || o_is_close;

endmodule

// File: rtl/brainhack_prog_loader.sv
// Filters a byte stream into program memory, checks bracket balance/depth, writes the terminator.
// Memory writes land one cycle after the accepting edge; ready is high only while loading.
module brainhack_prog_loader
  import brainhack_prog_loader_pkg::*;
#(
  parameter int unsigned c_prgmem_addr_width = 8,
  parameter int unsigned c_stack_addr_width  = 4
) (
  input  logic                           i_clock,
  input  logic                           i_reset_n,
  input  logic                           i_start,
  input  logic                           i_rx_valid,
  input  logic [7:0]                     i_rx_data,
  output logic                           o_rx_ready,
  output logic                           o_prgmem_we,
  output logic [c_prgmem_addr_width-1:0] o_prgmem_addr,
  output logic [7:0]                     o_prgmem_data,
  output logic                           o_core_hold,
  output logic                           o_done,
  output logic                           o_error,
  output logic [1:0]                     o_err_code,
  output logic [c_prgmem_addr_width-1:0] o_length
);

  localparam int unsigned W = c_prgmem_addr_width;
  localparam int unsigned D = c_stack_addr_width + 1;
  // Last address is kept free for the terminator.
  localparam logic [W-1:0] c_count_max = '1;
  localparam logic [D-1:0] c_depth_max = {1'b1, {c_stack_addr_width{1'b0}}};

  state_e         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [D-1:0]   depth_q, depth_d;
  logic           we_q, we_d;
  logic [W-1:0]   addr_q, addr_d;
  logic [7:0]     data_q, data_d;
  logic [1:0]     err_code_q, err_code_d;
  logic [W-1:0]   length_q, length_d;

  logic is_opcode, is_open, is_close, xfer;

  brainhack_opcode_decode u_decode (
    .i_byte      (i_rx_data),
    .o_is_opcode (is_opcode),
    .o_is_open   (is_open),
    .o_is_close  (is_close)
  );

  assign xfer = i_rx_valid && (state_q == ST_LOAD);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    depth_d    = depth_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    err_code_d = err_code_q;
    length_d   = length_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (i_start) begin
          state_d    = ST_LOAD;
          count_d    = '0;
          depth_d    = '0;
          err_code_d = c_err_none;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          if (is_opcode) begin
            if (count_q == c_count_max) begin
              state_d    = ST_ERR;
              err_code_d = c_err_overflow;
            end else if (is_close && depth_q == '0) begin
              state_d    = ST_ERR;
              err_code_d = c_err_unbalanced;
            end else if (is_open && depth_q == c_depth_max) begin
              state_d    = ST_ERR;
              err_code_d = c_err_nesting;
            end else begin
              we_d    = 1'b1;
              addr_d  = count_q;
              data_d  = i_rx_data;
              count_d = count_q + W'(1);
              if (is_open)  depth_d = depth_q + D'(1);
              if (is_close) depth_d = depth_q - D'(1);
            end
          end else if (i_rx_data == c_terminator) begin
            if (depth_q != '0) begin
              state_d    = ST_ERR;
              err_code_d = c_err_unbalanced;
            end else begin
              // Terminator write is registered here so it is on the port during TERM.
              state_d  = ST_TERM;
              we_d     = 1'b1;
              addr_d   = count_q;
              data_d   = c_terminator;
              length_d = count_q;
            end
          end
        end
      end
      ST_TERM: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      depth_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      err_code_q <= c_err_none;
      length_q   <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      depth_q    <= depth_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      err_code_q <= err_code_d;
      length_q   <= length_d;
    end
  end

  assign o_rx_ready    = (state_q == ST_LOAD);
  assign o_prgmem_we   = we_q;
  assign o_prgmem_addr = addr_q;
  assign o_prgmem_data = data_q;
  assign o_core_hold   = (state_q != ST_DONE);
  assign o_done        = (state_q == ST_DONE);
  assign o_error       = (state_q == ST_ERR);
  assign o_err_code    = err_code_q;
  assign o_length      = length_q;

endmodule

// File: tb/tb_brainhack_prog_loader.sv
// Bench for brainhack_prog_loader: a string-level model predicts every memory write and the final status.
module tb_brainhack_prog_loader;

  localparam int W = 8;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_ready, we, hold, done, error;
  logic [W-1:0] addr, length;
  logic [7:0]   wdata;
  logic [1:0]   err_code;

  brainhack_prog_loader #(.c_prgmem_addr_width(W), .c_stack_addr_width(S)) dut (
    .i_clock       (clk),
    .i_reset_n     (rst_n),
    .i_start       (start),
    .i_rx_valid    (rx_valid),
    .i_rx_data     (rx_data),
    .o_rx_ready    (rx_ready),
    .o_prgmem_we   (we),
    .o_prgmem_addr (addr),
    .o_prgmem_data (wdata),
    .o_core_hold   (hold),
    .o_done        (done),
    .o_error       (error),
    .o_err_code    (err_code),
    .o_length      (length)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  stim[$];
  logic        exp_done, exp_err;
  logic [1:0]  exp_code;
  int          exp_len, n_send;
  bit          gaps;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every write strobe must match the next write the model predicted.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h, no write expected", addr, wdata);
      end else begin
        chk("write_addr_data", {16'h0, addr, wdata}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // Walks the byte string with the loader's rules: capacity 2^W-1 opcodes, max nesting 2^S.
  task automatic run_model();
    int cnt;
    int dep;
    logic [7:0] b;
    cnt = 0;
    dep = 0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_code = 2'b00;
    exp_len  = 0;
    n_send   = stim.size();
    for (int i = 0; i < stim.size(); i++) begin
      b = stim[i];
      if (b inside {8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C}) begin
        if (cnt == (1 << W) - 1) begin
          exp_err = 1'b1; exp_code = 2'b01; n_send = i + 1; break;
        end
        if (b == 8'h5D && dep == 0) begin
          exp_err = 1'b1; exp_code = 2'b10; n_send = i + 1; break;
        end
        if (b == 8'h5B && dep == (1 << S)) begin
          exp_err = 1'b1; exp_code = 2'b11; n_send = i + 1; break;
        end
        exp_q.push_back({8'(cnt), b});
        cnt++;
        if (b == 8'h5B) dep++;
        if (b == 8'h5D) dep--;
      end else if (b == 8'h00) begin
        n_send = i + 1;
        if (dep != 0) begin
          exp_err = 1'b1; exp_code = 2'b10;
        end else begin
          exp_q.push_back({8'(cnt), 8'h00});
          exp_done = 1'b1;
          exp_len  = cnt;
        end
        break;
      end
    end
  endtask

  task automatic add_str(input string s);
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_stream();
    int t;
    for (int i = 0; i < n_send; i++) begin
      if (gaps) begin
        rx_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      rx_valid = 1'b1;
      rx_data  = stim[i];
      t = 0;
      while (!rx_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!rx_ready) begin
        n_cmp++;
        n_fail++;
        $display("FAIL ready_timeout: byte %0d never accepted, ready %0b, required 1", i, rx_ready);
        rx_valid = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int t;
    t = 0;
    while (!(done || error) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!(done || error)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_finish_timeout: done %0b error %0b, required one of them high", tag, done, error);
    end
    @(negedge clk);
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_error"}, error, exp_err);
    chk({tag, "_err_code"}, err_code, exp_code);
    chk({tag, "_core_hold"}, hold, !exp_done);
    chk({tag, "_rx_ready"}, rx_ready, 1'b0);
    if (exp_done) chk({tag, "_length"}, length, exp_len);
    chk({tag, "_writes_left"}, exp_q.size(), 0);
  endtask

  task automatic load(input string tag, input bit with_gaps);
    gaps = with_gaps;
    run_model();
    pulse_start();
    send_stream();
    wait_end(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_core_hold", hold, 1'b1);
    chk("rst_rx_ready", rx_ready, 1'b0);
    chk("rst_we", we, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_err_code", err_code, 2'b00);
    chk("rst_length", length, 0);
    chk("rst_addr_data", {addr, wdata}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    stim.delete(); add_str("+[->+<]"); stim.push_back(8'h00);
    load("loop", 1'b0);
    chk("loop_length_lit", length, 7);
    chk("loop_done_lit", done, 1'b1);

    stim.delete(); add_str("+ a\n-"); stim.push_back(8'h00);
    load("filter", 1'b1);
    chk("filter_length_lit", length, 2);

    stim.delete(); add_str("]");
    load("close_first", 1'b0);
    chk("close_first_code_lit", err_code, 2'b10);

    stim.delete(); add_str("[["); stim.push_back(8'h00);
    load("open_unclosed", 1'b1);
    chk("open_unclosed_code_lit", err_code, 2'b10);

    stim.delete(); for (int i = 0; i < 17; i++) stim.push_back(8'h5B);
    load("nest", 1'b0);
    chk("nest_code_lit", err_code, 2'b11);
    chk("nest_hold_lit", hold, 1'b1);

    stim.delete(); for (int i = 0; i < 256; i++) stim.push_back(8'h2B);
    load("overflow", 1'b0);
    chk("overflow_code_lit", err_code, 2'b01);

    stim.delete(); add_str("."); stim.push_back(8'h00);
    load("recover", 1'b0);
    chk("recover_length_lit", length, 1);

    stim.delete(); stim.push_back(8'h00);
    load("empty", 1'b0);
    chk("empty_length_lit", length, 0);

    // Reset between clock edges while a load is in progress.
    stim.delete(); add_str("+++");
    gaps = 1'b0;
    run_model();
    pulse_start();
    send_stream();
    #2;
    rx_valid = 1'b1;
    rx_data  = 8'h2B;
    rst_n    = 1'b0;
    #1;
    chk("async_rst_we", we, 1'b0);
    chk("async_rst_hold", hold, 1'b1);
    chk("async_rst_ready", rx_ready, 1'b0);
    chk("async_rst_error_done", {error, done}, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    rx_valid = 1'b0;
    chk("async_rst_writes_left", exp_q.size(), 0);
    chk("async_rst_idle_hold", hold, 1'b1);

    stim.delete(); add_str("+."); stim.push_back(8'h00);
    load("after_reset", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
